loop_softstart_seq: RTL and testbench

- Clocked sequencer for the step-down converter LOOP/CONTROL section.
- Owns power-up, precharge, soft-start ramp of the loop reference code, regulation handover, and fault shutdown with timed retry.
- Its outputs drive the loop-control digital buffers: driver enable, precharge switch, reference DAC code and power-good.
- Sits between the chip-level enable/protection comparators and the buck power stage.

---
 rtl/loop_seq_pkg.sv | 31 +++
 rtl/loop_seq_sync2.sv | 24 ++
 rtl/loop_softstart_seq.sv | 162 ++++++++++++++++
 tb/tb_loop_softstart_seq.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/loop_seq_pkg.sv
// Shared types and defaults for the buck loop soft-start sequencer.
// The state codes are exported as plain constants so a bench can compare the debug port.
package loop_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_PRECHG    = 3'd1,
        ST_SOFTSTART = 3'd2,
        ST_REGULATE  = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    localparam int DEF_DAC_W       = 8;
    localparam int DEF_SS_STEP_DIV = 16;
    localparam int DEF_PRECHG_CYC  = 64;
    localparam int DEF_RETRY_CYC   = 1024;
    localparam int DEF_OC_FILT     = 3;

    localparam logic [2:0] SC_OFF       = 3'd0;
    localparam logic [2:0] SC_PRECHG    = 3'd1;
    localparam logic [2:0] SC_SOFTSTART = 3'd2;
    localparam logic [2:0] SC_REGULATE  = 3'd3;
    localparam logic [2:0] SC_FAULT     = 3'd4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/loop_seq_sync2.sv
// Two-flop synchronizer for an asynchronous comparator input.
module loop_seq_sync2 (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/loop_softstart_seq.sv
// Power-up / precharge / soft-start / regulate / hiccup-retry sequencer for the buck loop.
// Outputs are registered from the next state so they change on the same edge as state.
module loop_softstart_seq
    import loop_seq_pkg::*;
#(
    parameter int DAC_W       = DEF_DAC_W,
    parameter int SS_STEP_DIV = DEF_SS_STEP_DIV,
    parameter int PRECHG_CYC  = DEF_PRECHG_CYC,
    parameter int RETRY_CYC   = DEF_RETRY_CYC,
    parameter int OC_FILT     = DEF_OC_FILT
) (
    input  logic             CELCLK,
    input  logic             CELRSTN,
    input  logic             CELV,
    input  logic             CELG,
    input  logic             SUB,
    input  logic             en,
    input  logic [DAC_W-1:0] vref_tgt,
    input  logic             oc,
    input  logic             uv,
    output logic [DAC_W-1:0] ref_code,
    output logic             drv_en,
    output logic             prechg,
    output logic             pg,
    output logic             fault,
    output logic [2:0]       state
);

    localparam int CNT_MAX = max3(PRECHG_CYC, RETRY_CYC, SS_STEP_DIV);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int OCF_W   = $clog2(OC_FILT + 1);

    localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRECHG_CYC - 1);
    localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_CYC - 1);
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(SS_STEP_DIV - 1);
    localparam logic [OCF_W-1:0] OCF_LAST   = OCF_W'(OC_FILT - 1);

    // Supply/substrate pins carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

    logic oc_s;
    logic uv_s;

    loop_seq_sync2 u_sync_oc (.clk_i(CELCLK), .rst_n_i(CELRSTN), .d_i(oc), .q_o(oc_s));
    loop_seq_sync2 u_sync_uv (.clk_i(CELCLK), .rst_n_i(CELRSTN), .d_i(uv), .q_o(uv_s));

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   tmr_q,    tmr_d;
    logic [CNT_W-1:0]   div_q,    div_d;
    logic [OCF_W-1:0]   ocf_q,    ocf_d;
    logic [DAC_W-1:0]   ref_q,    ref_d;
    logic               drv_q,    drv_d;
    logic               pre_q,    pre_d;
    logic               pg_q,     pg_d;
    logic               flt_q,    flt_d;
    logic               abort;
    logic               oc_trip;

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            state_q <= ST_OFF;
            tmr_q   <= '0;
            div_q   <= '0;
            ocf_q   <= '0;
            ref_q   <= '0;
            drv_q   <= 1'b0;
            pre_q   <= 1'b0;
            pg_q    <= 1'b0;
            flt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            div_q   <= div_d;
            ocf_q   <= ocf_d;
            ref_q   <= ref_d;
            drv_q   <= drv_d;
            pre_q   <= pre_d;
            pg_q    <= pg_d;
            flt_q   <= flt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        div_d   = div_q;
        ref_d   = ref_q;
        ocf_d   = '0;
        oc_trip = 1'b0;
        // A running retry is never cut short; its exit check decides OFF vs PRECHG.
        abort   = (state_q != ST_FAULT) && (uv_s || !en);

        if (oc_s && (state_q == ST_SOFTSTART || state_q == ST_REGULATE)) begin
            ocf_d   = ocf_q + 1'b1;
            oc_trip = (ocf_q == OCF_LAST);
        end

        if (abort) begin
            state_d = ST_OFF;
        end else if (oc_trip) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (en && !uv_s) state_d = ST_PRECHG;
                end
                ST_PRECHG: begin
                    if (tmr_q == PRE_LAST) state_d = ST_SOFTSTART;
                    else                   tmr_d   = tmr_q + 1'b1;
                end
                ST_SOFTSTART: begin
                    // Target at or below the ramp hands over; REGULATE ramps down if needed.
                    if (ref_q >= vref_tgt) begin
                        state_d = ST_REGULATE;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        ref_d = ref_q + 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_REGULATE: begin
                    // Divider idles at zero on target so a retarget always waits a full step.
                    if (ref_q == vref_tgt) begin
                        div_d = '0;
                    end else if (div_q == DIV_LAST) begin
                        div_d = '0;
                        ref_d = (vref_tgt > ref_q) ? ref_q + 1'b1 : ref_q - 1'b1;
                    end else begin
                        div_d = div_q + 1'b1;
                    end
                end
                ST_FAULT: begin
                    if (tmr_q == RETRY_LAST) state_d = (en && !uv_s) ? ST_PRECHG : ST_OFF;
                    else                     tmr_d   = tmr_q + 1'b1;
                end
                default: state_d = ST_OFF;
            endcase
        end

        if (state_d != state_q) begin
            tmr_d = '0;
            div_d = '0;
            ocf_d = '0;
        end
        if (state_d inside {ST_OFF, ST_PRECHG, ST_FAULT}) ref_d = '0;

        drv_d = state_d inside {ST_SOFTSTART, ST_REGULATE};
        pre_d = (state_d == ST_PRECHG);
        pg_d  = (state_d == ST_REGULATE);
        flt_d = (state_d == ST_FAULT);
    end

    assign ref_code = ref_q;
    assign drv_en   = drv_q;
    assign prechg   = pre_q;
    assign pg       = pg_q;
    assign fault    = flt_q;
    assign state    = state_q;

endmodule

// File: tb/tb_loop_softstart_seq.sv
// Directed bench for loop_softstart_seq with short timing parameters.
module tb_loop_softstart_seq;
    import loop_seq_pkg::*;

    logic       CELCLK   = 1'b0;
    logic       CELRSTN  = 1'b0;
    logic       CELV     = 1'b1;
    logic       CELG     = 1'b0;
    logic       SUB      = 1'b0;
    logic       en       = 1'b0;
    logic [7:0] vref_tgt = 8'd5;
    logic       oc       = 1'b0;
    logic       uv       = 1'b0;
    logic [7:0] ref_code;
    logic       drv_en, prechg, pg, fault;
    logic [2:0] state;

    int n_chk  = 0;
    int n_pass = 0;

    loop_softstart_seq #(
        .DAC_W(8), .SS_STEP_DIV(4), .PRECHG_CYC(8), .RETRY_CYC(32), .OC_FILT(3)
    ) dut (
        .CELCLK(CELCLK), .CELRSTN(CELRSTN), .CELV(CELV), .CELG(CELG), .SUB(SUB),
        .en(en), .vref_tgt(vref_tgt), .oc(oc), .uv(uv),
        .ref_code(ref_code), .drv_en(drv_en), .prechg(prechg), .pg(pg),
        .fault(fault), .state(state)
    );

    always #5 CELCLK = ~CELCLK;

    // {state, ref_code, drv_en, prechg, pg, fault}
    function automatic logic [14:0] e_off();
        return 15'd0;
    endfunction
    function automatic logic [14:0] e_pre();
        return {SC_PRECHG, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] e_ss(input logic [7:0] r);
        return {SC_SOFTSTART, r, 1'b1, 1'b0, 1'b0, 1'b0};
    endfunction
    function automatic logic [14:0] e_reg(input logic [7:0] r);
        return {SC_REGULATE, r, 1'b1, 1'b0, 1'b1, 1'b0};
    endfunction
    function automatic logic [14:0] e_flt();
        return {SC_FAULT, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CELCLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = {state, ref_code, drv_en, prechg, pg, fault};
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed st=%0d ref=%0d drv/pre/pg/flt=%b expected st=%0d ref=%0d drv/pre/pg/flt=%b",
                    tag, obs[14:12], obs[11:4], obs[3:0], exp[14:12], exp[11:4], exp[3:0]);
    endtask

    initial begin
        // reset, with en already high while held
        tick(2);
        chk("reset", e_off());
        en = 1'b1;
        tick(1);
        chk("reset_hold_en", e_off());
        CELRSTN = 1'b1;

        // nominal start
        tick(1);  chk("prechg_enter", e_pre());
        tick(7);  chk("prechg_last", e_pre());
        tick(1);  chk("ss_enter", e_ss(8'd0));
        for (int k = 1; k <= 5; k++) begin
            tick(3); chk("ss_hold", e_ss(8'(k - 1)));
            tick(1); chk("ss_step", e_ss(8'(k)));
        end
        tick(1);  chk("reg_enter", e_reg(8'd5));

        // two-sample oc glitch must not trip
        oc = 1'b1; tick(2); oc = 1'b0;
        tick(6);  chk("oc_glitch", e_reg(8'd5));

        // held oc trips on third synchronized sample, then hiccup retry
        oc = 1'b1;
        tick(4);  chk("oc_two_samples", e_reg(8'd5));
        tick(1);  chk("oc_trip", e_flt());
        oc = 1'b0;
        tick(31); chk("retry_wait", e_flt());
        tick(1);  chk("retry_prechg", e_pre());
        tick(8);  chk("retry_ss", e_ss(8'd0));
        tick(21); chk("retry_reg", e_reg(8'd5));

        // retarget down then up in REGULATE
        vref_tgt = 8'd2;
        tick(3);  chk("rt_hold", e_reg(8'd5));
        tick(1);  chk("rt_4", e_reg(8'd4));
        tick(3);  chk("rt_hold4", e_reg(8'd4));
        tick(1);  chk("rt_3", e_reg(8'd3));
        tick(4);  chk("rt_2", e_reg(8'd2));
        tick(4);  chk("rt_settled", e_reg(8'd2));
        vref_tgt = 8'd5;
        tick(11); chk("rt_up_4", e_reg(8'd4));
        tick(1);  chk("rt_up_5", e_reg(8'd5));

        // en drop coincident with third oc sample: OFF, no fault
        oc = 1'b1;
        tick(4);  chk("sim_pre", e_reg(8'd5));
        en = 1'b0;
        tick(1);  chk("sim_off", e_off());
        oc = 1'b0;
        tick(2);

        // uv during ramp
        en = 1'b1;
        tick(1);  chk("uv_prechg", e_pre());
        tick(8);  chk("uv_ss", e_ss(8'd0));
        tick(12); chk("uv_ref3", e_ss(8'd3));
        uv = 1'b1;
        tick(2);  chk("uv_sync", e_ss(8'd3));
        tick(1);  chk("uv_off", e_off());
        uv = 1'b0; en = 1'b0;
        tick(3);  chk("uv_stay_off", e_off());

        // async reset mid soft-start
        en = 1'b1;
        tick(1);  chk("ar_prechg", e_pre());
        tick(8);  chk("ar_ss", e_ss(8'd0));
        tick(6);  chk("ar_ref1", e_ss(8'd1));
        #2 CELRSTN = 1'b0;
        #1 chk("ar_async", e_off());
        tick(1);  chk("ar_held", e_off());
        CELRSTN = 1'b1;
        tick(1);  chk("ar_prechg2", e_pre());
        tick(7);  chk("ar_prechg2_last", e_pre());
        tick(1);  chk("ar_ss2", e_ss(8'd0));

        // zero target hands over immediately
        en = 1'b0;
        tick(1);  chk("z_off", e_off());
        vref_tgt = 8'd0; en = 1'b1;
        tick(1);  chk("z_prechg", e_pre());
        tick(8);  chk("z_ss", e_ss(8'd0));
        tick(1);  chk("z_reg", e_reg(8'd0));

        // en low during retry does not abort the timer; exit goes OFF
        oc = 1'b1;
        tick(4);  chk("f_pre", e_reg(8'd0));
        tick(1);  chk("f_trip", e_flt());
        oc = 1'b0; en = 1'b0;
        tick(31); chk("f_wait_en0", e_flt());
        tick(1);  chk("f_exit_off", e_off());

        // target drops below ramp during soft-start
        vref_tgt = 8'd5; en = 1'b1;
        tick(1);  chk("d_prechg", e_pre());
        tick(8);  chk("d_ss", e_ss(8'd0));
        tick(8);  chk("d_ref2", e_ss(8'd2));
        vref_tgt = 8'd1;
        tick(1);  chk("d_reg", e_reg(8'd2));
        tick(3);  chk("d_hold", e_reg(8'd2));
        tick(1);  chk("d_down", e_reg(8'd1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
